if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Fetch-side counterpart of the next-PC logic: holds the architectural fetch PC and issues instruction-memory requests.
- Captures returned instructions into the IF/ID pipeline register.
- Sequential fetch (PC+4) is generated internally; taken branches, JAL and JALR arrive from EX as a redirect carrying the resolved target.
- Exports the current PC so the next-PC logic can compute targets.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value of ifid_instr whenever ifid_valid=0

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- stall_if  input  1  hazard unit holds IF and IF/ID this cycle
- redirect_valid  input  1  EX resolved a taken control transfer; flushes IF/ID
- redirect_pc  input  32  target address, valid when redirect_valid=1
- imem_req  output  1  instruction-memory request
- imem_addr  output  32  request address, registered, stable while imem_req=1
- imem_ack  input  1  memory returns data; may assert in the same cycle as imem_req
- imem_rdata  input  32  instruction, valid when imem_ack=1
- pc_o  output  32  current fetch PC, fed to next-PC logic
- ifid_valid  output  1  IF/ID holds a real instruction
- ifid_pc  output  32  PC of the IF/ID instruction
- ifid_pcplus4  output  32  ifid_pc+4
- ifid_instr  output  32  instruction word

Behaviour:
- Reset values:
  - pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, state=IDLE
  - ifid_valid=0, ifid_pc=0, ifid_pcplus4=0, ifid_instr=NOP_INSTR, hold buffer cleared
- Reset mid-request abandons the request. The memory must tolerate imem_req dropping without ack on reset only.
- States:
  - IDLE: one cycle after reset, imem_req=0. Next state REQ with imem_addr=pc.
  - REQ: imem_req=1 with imem_addr.
  - HOLD: instruction received while stalled; imem_req=0.
  - DISCARD: a redirect arrived while a request was unacked. imem_req=1 with the old address until ack.
- Request rule: once imem_req=1 it stays high and imem_addr stays constant until imem_ack.
- REQ, imem_ack=1:
  - If redirect_valid: drop data; pc, imem_addr <= redirect_pc; stay REQ; ifid_valid<=0.
  - Else if stall_if: buffer {pc, imem_rdata}; go to HOLD; IF/ID unchanged.
  - Else: IF/ID <= {1, pc, pc+4, imem_rdata}; pc, imem_addr <= pc+4; stay REQ. This gives 1 instruction/cycle with zero-wait memory.
- REQ, imem_ack=0:
  - If redirect_valid: pc<=redirect_pc; imem_addr unchanged; go to DISCARD.
  - Else if !stall_if: ifid_valid<=0 (bubble).
- DISCARD:
  - A further redirect overwrites pc.
  - On ack: drop data; imem_addr<=pc (or redirect_pc if redirect that cycle); go to REQ.
  - ifid_valid<=0 whenever !stall_if or redirect.
- HOLD:
  - If redirect_valid: drop buffer; pc, imem_addr <= redirect_pc; go to REQ; ifid_valid<=0.
  - Else if !stall_if: IF/ID <= buffer (valid=1); pc, imem_addr <= pc+4; go to REQ.
  - Else: remain in HOLD.
- Priority: rst > redirect_valid > stall_if > normal advance. A redirect always clears ifid_valid next cycle, even under stall.
- Arithmetic: PC increments modulo 2^32 (0xFFFF_FFFC+4 wraps to 0). Low two bits of redirect_pc are passed through unchanged; alignment faults are handled elsewhere.
- pc_o = pc register (not imem_addr). During DISCARD, pc_o already shows the redirect target.
- ifid_pcplus4 is always registered together with ifid_pc.

Test Plan:
- Reset, imem_ack tied high:
  - imem_req=0 in the cycle after reset.
  - Addresses 0x0, 0x4, 0x8 on consecutive cycles.
  - ifid_pc follows one cycle behind with ifid_valid=1.
- Wait states, ack after 2 cycles per request:
  - ifid_valid=0 bubbles while waiting.
  - imem_addr stable across waits.
  - Each instruction is delivered exactly once.
- stall_if=1 for 3 cycles while an ack arrives at 0x10:
  - IF/ID frozen and state HOLD with imem_req=0.
  - After release, ifid_pc=0x10 and the next request is 0x14.
- Redirect to 0x100 while the request at 0x20 is unacked:
  - imem_addr stays 0x20 until ack; its data is dropped.
  - The next request is 0x100; no instruction from 0x20 reaches IF/ID.
- Redirect together with stall_if=1:
  - ifid_valid=0 next cycle.
  - The next fetch is the redirect target.
- RESET_PC=0xFFFF_FFFC, zero-wait memory:
  - Addresses 0xFFFF_FFFC, then 0x0.
  - ifid_pcplus4=0x0 for the first instruction.

Source files
------------

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch: fetch PC, imem request handshake, IF/ID register
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pcplus4,
    output logic [31:0] ifid_instr
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, addr_n, pc_inc;
    logic [31:0] hold_pc, hold_pc_n, hold_instr, hold_instr_n;
    logic        valid_n;
    logic [31:0] ipc_n, ip4_n, iin_n;

    assign pc_inc   = pc + 32'd4;
    assign pc_o     = pc;
    assign imem_req = (state == REQ) || (state == DISCARD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            imem_addr    <= RESET_PC;
            hold_pc      <= 32'd0;
            hold_instr   <= 32'd0;
            ifid_valid   <= 1'b0;
            ifid_pc      <= 32'd0;
            ifid_pcplus4 <= 32'd0;
            ifid_instr   <= NOP_INSTR;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            imem_addr    <= addr_n;
            hold_pc      <= hold_pc_n;
            hold_instr   <= hold_instr_n;
            ifid_valid   <= valid_n;
            ifid_pc      <= ipc_n;
            ifid_pcplus4 <= ip4_n;
            ifid_instr   <= iin_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        addr_n       = imem_addr;
        hold_pc_n    = hold_pc;
        hold_instr_n = hold_instr;
        valid_n      = ifid_valid;
        ipc_n        = ifid_pc;
        ip4_n        = ifid_pcplus4;
        iin_n        = ifid_instr;
        case (state)
            IDLE: begin
                state_n = REQ;
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    addr_n  = redirect_pc;
                    valid_n = 1'b0;
                end else begin
                    addr_n = pc;
                end
            end
            REQ: begin
                // In REQ the pc register always equals imem_addr.
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_n    = redirect_pc;
                        addr_n  = redirect_pc;
                        valid_n = 1'b0;
                    end else if (stall_if) begin
                        hold_pc_n    = pc;
                        hold_instr_n = imem_rdata;
                        state_n      = HOLD;
                    end else begin
                        valid_n = 1'b1;
                        ipc_n   = pc;
                        ip4_n   = pc_inc;
                        iin_n   = imem_rdata;
                        pc_n    = pc_inc;
                        addr_n  = pc_inc;
                    end
                end else if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                    state_n = DISCARD;
                end else if (!stall_if) begin
                    valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    addr_n  = redirect_pc;
                    valid_n = 1'b0;
                    state_n = REQ;
                end else if (!stall_if) begin
                    valid_n = 1'b1;
                    ipc_n   = hold_pc;
                    ip4_n   = hold_pc + 32'd4;
                    iin_n   = hold_instr;
                    pc_n    = pc_inc;
                    addr_n  = pc_inc;
                    state_n = REQ;
                end
            end
            DISCARD: begin
                // Old request must complete; its data is never used.
                if (redirect_valid)
                    pc_n = redirect_pc;
                if (imem_ack) begin
                    addr_n  = redirect_valid ? redirect_pc : pc;
                    state_n = REQ;
                end
                if (!stall_if || redirect_valid)
                    valid_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
        if (!valid_n)
            iin_n = NOP_INSTR;
    end

endmodule
